// File: rtl/mpeg_dsp_pkg.sv
// mpeg_dsp_pkg: DSP register write bus addresses, command bytes, attenuation types
// and writer state encoding shared by the volume writer.
package mpeg_dsp_pkg;
    localparam logic [7:0] DSPA_MODE        = 8'd0;
    localparam logic [7:0] DSPA_TARGET      = 8'd1;
    localparam logic [7:0] DSPA_ATTENUATION = 8'd7;
    localparam logic [7:0] DSP_MODE_ATT     = 8'h80;
    localparam logic [7:0] DSP_TARGET_ATT   = 8'h93;
    localparam logic [7:0] DSP_ATT_MUTE     = 8'h80;
    localparam logic [6:0] DSP_ATT_MAX_DB   = 7'd60;

    typedef logic [3:0][7:0] attenuation_set_t;

    typedef enum logic [2:0] {IDLE, MODE, TGT0, TGT1, ATT, FIN} wr_state_t;

    // Attenuation beyond the receiver's usable range is sent as mute instead.
    function automatic logic [7:0] clamp_att(input logic [7:0] b);
        return (!b[7] && b[6:0] > DSP_ATT_MAX_DB) ? DSP_ATT_MUTE : b;
    endfunction
endpackage

// File: rtl/dsp_strobe_pacer.sv
// dsp_strobe_pacer: enforces STROBE_GAP idle cycles after each fired strobe.
module dsp_strobe_pacer #(
    parameter int unsigned STROBE_GAP = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic fire,
    output logic ready
);
    localparam int W = STROBE_GAP > 0 ? $clog2(STROBE_GAP + 1) : 1;
    logic [W-1:0] cnt;
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt <= '0;
        else if (fire) cnt <= W'(STROBE_GAP);
        else if (cnt != '0) cnt <= cnt - W'(1);
    assign ready = cnt == '0;
endmodule

// File: rtl/dsp_volume_writer.sv
// dsp_volume_writer: emits the 7-write DSP bus sequence loading four attenuation slots.
// Define DSP_ATT_CLAMP_EN to replace out-of-range attenuation bytes with mute at latch time.
module dsp_volume_writer
    import mpeg_dsp_pkg::*;
#(
    parameter int unsigned STROBE_GAP = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  attenuation_set_t req_att,
    output logic [7:0]       dspa,
    output logic [7:0]       dspd,
    output logic             dspd_strobe,
    output logic             busy,
    output logic             done
);
    wr_state_t        state, state_n;
    logic [1:0]       idx, idx_n;
    attenuation_set_t att_q, att_in;
    logic [7:0]       dspa_n, dspd_n;
    logic             fire, ready, accept;

    assign req_ready = state == IDLE;
    assign busy      = state != IDLE;
    assign done      = state == FIN;
    assign accept    = req_valid && req_ready;

`ifdef DSP_ATT_CLAMP_EN
    always_comb
        for (int i = 0; i < 4; i++) att_in[i] = clamp_att(req_att[i]);
`else
    assign att_in = req_att;
`endif

    dsp_strobe_pacer #(.STROBE_GAP(STROBE_GAP)) u_pacer (
        .clk  (clk),
        .reset(reset),
        .fire (fire),
        .ready(ready)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state       <= IDLE;
            idx         <= 2'd0;
            att_q       <= '0;
            dspa        <= 8'd0;
            dspd        <= 8'd0;
            dspd_strobe <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            dspa        <= dspa_n;
            dspd        <= dspd_n;
            dspd_strobe <= fire;
            if (accept) att_q <= att_in;
        end

    // Strobe registers are loaded on entry to each write, so address/data change with the strobe.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        fire    = 1'b0;
        dspa_n  = dspa;
        dspd_n  = dspd;
        case (state)
            IDLE: if (req_valid) begin
                state_n = MODE;
                fire    = 1'b1;
                dspa_n  = DSPA_MODE;
                dspd_n  = DSP_MODE_ATT;
            end
            MODE: if (ready) begin
                state_n = TGT0;
                fire    = 1'b1;
                dspa_n  = DSPA_TARGET;
                dspd_n  = DSP_TARGET_ATT;
            end
            TGT0: if (ready) begin
                state_n = TGT1;
                fire    = 1'b1;
                dspa_n  = DSPA_TARGET;
                dspd_n  = DSP_TARGET_ATT;
            end
            TGT1: if (ready) begin
                state_n = ATT;
                idx_n   = 2'd0;
                fire    = 1'b1;
                dspa_n  = DSPA_ATTENUATION;
                dspd_n  = att_q[0];
            end
            ATT: if (dspd_strobe && idx == 2'd3) begin
                state_n = FIN;
                idx_n   = 2'd0;
            end else if (ready) begin
                idx_n   = idx + 2'd1;
                fire    = 1'b1;
                dspa_n  = DSPA_ATTENUATION;
                dspd_n  = att_q[idx_n];
            end
            FIN: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dsp_volume_writer.sv
// tb_dsp_volume_writer: randomized check of the volume writer against a receiver model.
module tb_dsp_volume_writer;
    import mpeg_dsp_pkg::*;
    localparam int G = 1;

    logic clk = 1'b0, reset = 1'b1, req_valid = 1'b0;
    logic req_ready, dspd_strobe, busy, done;
    logic [7:0] dspa, dspd;
    attenuation_set_t req_att = '0;

    logic v0 = 1'b0, r0, s0, b0, d0;
    logic [7:0] dspa0, dspd0;
    attenuation_set_t a0 = '0;

    int nchk = 0, nerr = 0, cyc = 0;
    logic [7:0] qa[$], qd[$];
    int qc[$];
    logic [7:0] rx_mode = 8'd0, rx_tgt = 8'd0;
    logic [7:0] rx_slot[4] = '{default: 8'd0};
    int rx_idx = 0;

    dsp_volume_writer #(.STROBE_GAP(G)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_att(req_att), .dspa(dspa), .dspd(dspd), .dspd_strobe(dspd_strobe),
        .busy(busy), .done(done)
    );

    dsp_volume_writer #(.STROBE_GAP(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(v0), .req_ready(r0),
        .req_att(a0), .dspa(dspa0), .dspd(dspd0), .dspd_strobe(s0),
        .busy(b0), .done(d0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Receiver model: slot index resets only when target already held 0x93.
    always @(negedge clk) if (dspd_strobe) begin
        qa.push_back(dspa);
        qd.push_back(dspd);
        qc.push_back(cyc);
        if (dspa == 8'd0) rx_mode = dspd;
        else if (dspa == 8'd1) begin
            if (rx_tgt == 8'h93) rx_idx = 0;
            rx_tgt = dspd;
        end else if (dspa == 8'd7 && rx_mode == 8'h80 && rx_tgt == 8'h93) begin
            rx_slot[rx_idx % 4] = dspd;
            rx_idx++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_byte(input logic [7:0] b);
`ifdef DSP_ATT_CLAMP_EN
        if (b < 8'd128 && b > 8'd60) return 8'h80;
`endif
        return b;
    endfunction

    function automatic attenuation_set_t rnd_set();
        attenuation_set_t s;
        for (int i = 0; i < 4; i++) s[i] = 8'($urandom_range(0, 255));
        return s;
    endfunction

    // Called at a negedge with the writer idle or about to become idle.
    task automatic send(input attenuation_set_t a, input bit hold);
        int t_acc, t_done, n;
        logic [7:0] e[7];
        e[0] = 8'h80; e[1] = 8'h93; e[2] = 8'h93;
        for (int i = 0; i < 4; i++) e[3+i] = model_byte(a[i]);
        qa.delete(); qd.delete(); qc.delete();
        req_att = a;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        chk("accept_wait", 32'(n < 100), 1);
        t_acc = cyc + 1;
        @(negedge clk);
        chk("busy_first", busy, 1);
        if (!hold) req_valid = 1'b0;
        n = 0;
        while (!done && n < 100) begin @(negedge clk); n++; end
        t_done = cyc;
        chk("done_time", t_done - t_acc, 6 * (G + 1) + 1);
        chk("busy_at_done", busy, 1);
        chk("ready_at_done", req_ready, 0);
        @(negedge clk);
        chk("ready_after_done", req_ready, 1);
        chk("busy_after_done", busy, 0);
        chk("strobe_count", qa.size(), 7);
        for (int k = 0; k < 7 && k < qa.size(); k++) begin
            chk("addr", qa[k], k == 0 ? 32'd0 : (k < 3 ? 32'd1 : 32'd7));
            chk("data", qd[k], e[k]);
            chk("strobe_time", qc[k] - t_acc, k * (G + 1));
        end
        for (int i = 0; i < 4; i++) chk("rx_slot", rx_slot[i], e[3+i]);
    endtask

    task automatic reset_mid_sequence();
        int n, cnt;
        qa.delete(); qd.delete(); qc.delete();
        req_att = rnd_set();
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 1'b0;
        cnt = 0;
        n = 0;
        while (n < 100) begin
            if (dspd_strobe) cnt++;
            if (cnt == 4) break;
            @(negedge clk);
            n++;
        end
        chk("rst_reach4", cnt, 4);
        reset = 1'b1;
        #1;
        chk("rst_strobe", dspd_strobe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", req_ready, 1);
        chk("rst_dspa", dspa, 0);
        chk("rst_dspd", dspd, 0);
        repeat (4) @(negedge clk);
        chk("rst_no_more_strobes", qa.size(), 4);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic gap0_test();
        int n;
        logic [7:0] e[7];
        a0 = rnd_set();
        e[0] = 8'h80; e[1] = 8'h93; e[2] = 8'h93;
        for (int i = 0; i < 4; i++) e[3+i] = model_byte(a0[i]);
        v0 = 1'b1;
        n = 0;
        while (!r0 && n < 100) begin @(negedge clk); n++; end
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            v0 = 1'b0;
            chk("g0_strobe", s0, 1);
            chk("g0_addr", dspa0, k == 0 ? 32'd0 : (k < 3 ? 32'd1 : 32'd7));
            chk("g0_data", dspd0, e[k]);
        end
        @(negedge clk);
        chk("g0_done", d0, 1);
        chk("g0_strobe_off", s0, 0);
        @(negedge clk);
        chk("g0_ready", r0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_strobe", dspd_strobe, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_ready", req_ready, 1);
        chk("reset_dspa", dspa, 0);
        chk("reset_dspd", dspd, 0);
        chk("reset_g0_ready", r0, 1);
        reset = 1'b0;
        @(negedge clk);
        send({8'h00, 8'h80, 8'h80, 8'h00}, 1'b0);
        send({8'h28, 8'h1E, 8'h14, 8'h0A}, 1'b0);
        send({8'h7F, 8'hFF, 8'h3C, 8'h3D}, 1'b0);
        send(rnd_set(), 1'b1);
        send(rnd_set(), 1'b0);
        reset_mid_sequence();
        send(rnd_set(), 1'b0);
        for (int r = 0; r < 5; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(rnd_set(), 1'b0);
        end
        gap0_test();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/dsp_volume_writer.md
Name: dsp_volume_writer

Overview:
Initiator side of the FMA DSP register write bus (dspa/dspd/dspd_strobe). It takes a set of four attenuation bytes from the MPEG audio control logic and emits the exact write sequence that arms and loads the downstream volume receiver's attenuation slots 0..3. It sits between the FMA control register file and the DSP register receiver. It paces strobes to a configurable rate.

Parameters:
STROBE_GAP, 1, number of idle cycles inserted between consecutive strobes; 0 means back-to-back strobes.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request carries a new attenuation set
req_ready  out  1  writer idle and able to accept
req_att  in  4x8  attenuation bytes; [i] is loaded into downstream slot i; bit7=1 means mute, otherwise [6:0] is the dB attenuation
dspa  out  8  DSP register address
dspd  out  8  DSP register data
dspd_strobe  out  1  one-cycle write strobe
busy  out  1  sequence in progress
done  out  1  one-cycle pulse when the sequence completes

Behaviour:
- Reset values: dspa=0, dspd=0, dspd_strobe=0, busy=0, done=0, req_ready=1, state=IDLE.
- Handshake: a request is accepted on a clk edge where req_valid && req_ready. req_att is latched on that edge. req_ready=1 only in IDLE with done low. While busy, req_valid is ignored and nothing is latched.
- Write sequence: exactly 7 strobes, in this order:
  1. dspa=0, dspd=8'h80 (mode).
  2. dspa=1, dspd=8'h93 (target).
  3. dspa=1, dspd=8'h93 again. This write is mandatory: the receiver resets its slot index only when target already holds 0x93.
  4. dspa=7, dspd=att[0].
  5. dspa=7, dspd=att[1].
  6. dspa=7, dspd=att[2].
  7. dspa=7, dspd=att[3].
- States: IDLE -> MODE -> TGT0 -> TGT1 -> ATT (2-bit index 0..3) -> FIN -> IDLE.
  - A strobe state asserts dspd_strobe for exactly one cycle.
  - A GAP down-counter then holds the state for STROBE_GAP cycles before advancing.
  - ATT advances its index after each strobe. The index wraps 3->0 only on exit to FIN.
- Timing, with acceptance at edge T:
  - First strobe is high in cycle T+1.
  - Strobe k (k=0..6) is high in cycle T+1+k*(STROBE_GAP+1).
  - done pulses in the cycle after the last strobe.
  - req_ready returns high in the cycle after done.
  - busy is high from T+1 through the done cycle inclusive.
- dspa/dspd change only in the cycle their strobe rises. They hold their values during gaps and in IDLE.
- dspd_strobe is never high outside a strobe state, and never high for two consecutive cycles when STROBE_GAP>=1.
- Reset asserted mid-sequence: all outputs return to reset values immediately (asynchronous). No further strobes are issued. The partial downstream load is abandoned, and the next request re-sends the full 7-write sequence.
- Request presented in the same cycle done pulses: not accepted (req_ready=0). It is accepted one cycle later if still valid.
- No width arithmetic on data: bytes pass through unchanged, except as described under Optional Feature.

Optional Feature:
DSP_ATT_CLAMP_EN: when defined, any latched byte with bit7=0 and [6:0]>60 is replaced by 8'h80 (mute) before transmission. Clamping is applied at the latch edge. Without the macro, all bytes are transmitted verbatim.

Decomposition:
- Package mpeg_dsp_pkg holds:
  - constants DSPA_MODE=8'd0, DSPA_TARGET=8'd1, DSPA_ATTENUATION=8'd7;
  - constants DSP_MODE_ATT=8'h80, DSP_TARGET_ATT=8'h93, DSP_ATT_MUTE=8'h80, DSP_ATT_MAX_DB=7'd60;
  - typedef attenuation_set_t (4x8 packed array);
  - the state enum.
- One natural sub-module: dsp_strobe_pacer, the STROBE_GAP down-counter. It takes a fire input and returns a ready output.

Test Plan:
- STROBE_GAP=1, req_att={8'h00,8'h80,8'h80,8'h00} -> strobes at T+1,3,5,7,9,11,13 with (dspa,dspd) = (0,80),(1,93),(1,93),(7,00),(7,80),(7,80),(7,00); done at T+14; req_ready high at T+15.
- STROBE_GAP=0 -> 7 consecutive strobe cycles T+1..T+7; done at T+8.
- Feeding the writer into a receiver model -> model volume slots equal {00,80,80,00}; second request {0A,14,1E,28} -> slots overwritten in index order.
- req_valid held high while busy -> exactly one sequence is emitted; the second request is accepted the cycle after req_ready rises.
- Reset asserted after the 4th strobe -> dspd_strobe, busy and done fall immediately; the new request afterwards emits all 7 strobes starting with (0,80).
- With DSP_ATT_CLAMP_EN, req_att={3D,3C,FF,7F} -> dspa=7 data 80,3C,FF,80. Without the macro -> 3D,3C,FF,7F.
